// File: rtl/readout_tx_pkg.sv
// Shared widths, instruction field offsets and FSM encoding
// for the readout transmit waveform generator.
package readout_tx_pkg;

  localparam int READTX_NUM_QUBIT            = 6;
  localparam int READTX_QUBIT_ADDR_WIDTH     = 3;
  localparam int READTX_GLB_COUNTER_WIDTH    = 28;
  localparam int READTX_INST_LIST_NUM_ENTRY  = 32;
  localparam int READTX_INST_LIST_ADDR_WIDTH = 5;
  localparam int READTX_INST_LIST_DATA_WIDTH = 50;
  localparam int READTX_NCO_N                = 24;
  localparam int READTX_PHASE_WIDTH          = 8;
  localparam int READTX_SIN_LUT_NUM_ENTRY    = 256;
  localparam int READTX_SIN_LUT_ADDR_WIDTH   = 8;
  localparam int READTX_SIN_LUT_DATA_WIDTH   = 16;
  localparam int READTX_OUTPUT_WIDTH         = 19;

  localparam int CH_EN_LSB = 0;
  localparam int LEN_LSB   = 6;
  localparam int START_LSB = 22;
  localparam int LEN_WIDTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic logic signed [READTX_OUTPUT_WIDTH-1:0] sext(
    input logic [READTX_SIN_LUT_DATA_WIDTH-1:0] s
  );
    return {{(READTX_OUTPUT_WIDTH-READTX_SIN_LUT_DATA_WIDTH){s[READTX_SIN_LUT_DATA_WIDTH-1]}}, s};
  endfunction

endpackage

// File: rtl/readout_tx_nco.sv
// Per-qubit NCO: FTW register plus phase accumulator
// with synchronous clear and step enable.
module readout_tx_nco
  import readout_tx_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ftw_we_i,
  input  logic [READTX_NCO_N-1:0]       ftw_i,
  input  logic                          clr_i,
  input  logic                          en_i,
  output logic [READTX_PHASE_WIDTH-1:0] phase_o
);

  logic [READTX_NCO_N-1:0] ftw_q;
  logic [READTX_NCO_N-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q + ftw_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_q <= '0;
      acc_q <= '0;
    end else begin
      if (ftw_we_i)
        ftw_q <= ftw_i;
      acc_q <= acc_d;
    end
  end

  assign phase_o = acc_q[READTX_NCO_N-1 -: READTX_PHASE_WIDTH];

endmodule

// File: rtl/readout_tx.sv
// Readout pulse generator: time-stamped instruction list driving
// a sum of per-qubit NCO sinusoids read from a shared sine LUT.
module readout_tx
  import readout_tx_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [READTX_GLB_COUNTER_WIDTH-1:0]    glb_counter,
  input  logic                                   inst_list_wr_en,
  input  logic [READTX_INST_LIST_ADDR_WIDTH-1:0] inst_list_wr_addr,
  input  logic [READTX_INST_LIST_DATA_WIDTH-1:0] inst_list_wr_data,
  input  logic [READTX_QUBIT_ADDR_WIDTH-1:0]     nco_ftw_wr_sel,
  input  logic                                   nco_ftw_wr_en,
  input  logic [READTX_NCO_N-1:0]                nco_ftw_in,
  input  logic                                   sin_lut_wr_en,
  input  logic [READTX_SIN_LUT_ADDR_WIDTH-1:0]   sin_lut_wr_addr,
  input  logic [READTX_SIN_LUT_DATA_WIDTH-1:0]   sin_lut_wr_data,
  output logic                                   valid_sin_wave_out,
  output logic signed [READTX_OUTPUT_WIDTH-1:0]  sin_wave_out
);

  logic [READTX_INST_LIST_DATA_WIDTH-1:0] inst_mem [READTX_INST_LIST_NUM_ENTRY];
  logic [READTX_SIN_LUT_DATA_WIDTH-1:0]   lut_mem  [READTX_SIN_LUT_NUM_ENTRY];

  state_e                                 state_q, state_d;
  logic [READTX_INST_LIST_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [READTX_NUM_QUBIT-1:0]            en_q, en_d;
  logic [LEN_WIDTH-1:0]                   rem_q, rem_d;
  logic                                   valid_d;
  logic signed [READTX_OUTPUT_WIDTH-1:0]  out_d;

  logic [READTX_INST_LIST_DATA_WIDTH-1:0] head;
  logic [LEN_WIDTH-1:0]                   head_len;
  logic [READTX_GLB_COUNTER_WIDTH-1:0]    head_start;
  logic                                   trig;
  logic                                   active;
  logic [READTX_PHASE_WIDTH-1:0]          phase [READTX_NUM_QUBIT];
  logic signed [READTX_OUTPUT_WIDTH-1:0]  sum;

  // Storage arrays are deliberately not reset.
  always_ff @(posedge clk) begin
    if (inst_list_wr_en)
      inst_mem[inst_list_wr_addr] <= inst_list_wr_data;
    if (sin_lut_wr_en)
      lut_mem[sin_lut_wr_addr] <= sin_lut_wr_data;
  end

  assign head       = inst_mem[ptr_q];
  assign head_len   = head[LEN_LSB +: LEN_WIDTH];
  assign head_start = head[START_LSB +: READTX_GLB_COUNTER_WIDTH];
  assign active     = (state_q == ACTIVE);
  assign trig       = !active && (head_len != '0)
                      && (head_start == glb_counter);

  for (genvar q = 0; q < READTX_NUM_QUBIT; q++) begin : g_nco
    readout_tx_nco u_nco (
      .clk      (clk),
      .rst      (rst),
      .ftw_we_i (nco_ftw_wr_en
                 && (nco_ftw_wr_sel == READTX_QUBIT_ADDR_WIDTH'(q))),
      .ftw_i    (nco_ftw_in),
      .clr_i    (trig),
      .en_i     (active),
      .phase_o  (phase[q])
    );
  end

  always_comb begin
    sum = '0;
    for (int q = 0; q < READTX_NUM_QUBIT; q++)
      if (en_q[q])
        sum = sum + sext(lut_mem[phase[q]]);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    out_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ACTIVE;
          en_d    = head[CH_EN_LSB +: READTX_NUM_QUBIT];
          rem_d   = head_len;
        end
      end
      ACTIVE: begin
        valid_d = 1'b1;
        out_d   = sum;
        rem_d   = rem_q - 1'b1;
        if (rem_q == LEN_WIDTH'(1)) begin
          state_d = IDLE;
          ptr_d   = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      ptr_q              <= '0;
      en_q               <= '0;
      rem_q              <= '0;
      valid_sin_wave_out <= 1'b0;
      sin_wave_out       <= '0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      en_q               <= en_d;
      rem_q              <= rem_d;
      valid_sin_wave_out <= valid_d;
      sin_wave_out       <= out_d;
    end
  end

endmodule

// File: tb/tb_readout_tx.sv
// Directed + randomized bench for readout_tx against a
// closed-form burst model (sample n of channel q = LUT[(n*ftw_q)>>16]).
module tb_readout_tx;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [27:0]        glb_counter = '0;
  logic               inst_list_wr_en = 1'b0;
  logic [4:0]         inst_list_wr_addr = '0;
  logic [49:0]        inst_list_wr_data = '0;
  logic [2:0]         nco_ftw_wr_sel = '0;
  logic               nco_ftw_wr_en = 1'b0;
  logic [23:0]        nco_ftw_in = '0;
  logic               sin_lut_wr_en = 1'b0;
  logic [7:0]         sin_lut_wr_addr = '0;
  logic [15:0]        sin_lut_wr_data = '0;
  logic               valid_sin_wave_out;
  logic signed [18:0] sin_wave_out;

  int errors = 0;
  int checks = 0;

  logic [49:0]        m_inst [32];
  logic signed [15:0] m_lut  [256];
  logic [23:0]        m_ftw  [6];
  int                 m_ptr = 0;
  bit                 m_act = 0;
  int                 m_n = 0;
  int                 m_len = 0;
  logic [5:0]         m_en = '0;
  int                 burst_cnt = 0;

  readout_tx dut (
    .clk                (clk),
    .rst                (rst),
    .glb_counter        (glb_counter),
    .inst_list_wr_en    (inst_list_wr_en),
    .inst_list_wr_addr  (inst_list_wr_addr),
    .inst_list_wr_data  (inst_list_wr_data),
    .nco_ftw_wr_sel     (nco_ftw_wr_sel),
    .nco_ftw_wr_en      (nco_ftw_wr_en),
    .nco_ftw_in         (nco_ftw_in),
    .sin_lut_wr_en      (sin_lut_wr_en),
    .sin_lut_wr_addr    (sin_lut_wr_addr),
    .sin_lut_wr_data    (sin_lut_wr_data),
    .valid_sin_wave_out (valid_sin_wave_out),
    .sin_wave_out       (sin_wave_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sample(input int n);
    int s = 0;
    for (int q = 0; q < 6; q++) begin
      if (m_en[q]) begin
        longint p = (longint'(n) * longint'(m_ftw[q])) % 64'd16777216;
        s += int'(m_lut[int'(p >> 16)]);
      end
    end
    return s;
  endfunction

  function automatic logic [49:0] mk(input int start, input int len, input int en);
    return {28'(start), 16'(len), 6'(en)};
  endfunction

  task automatic step(input int g);
    bit ev;
    int eo;
    glb_counter = 28'(g);
    @(posedge clk);
    ev = 0;
    eo = 0;
    if (rst) begin
      m_act = 0;
      m_ptr = 0;
      for (int q = 0; q < 6; q++) m_ftw[q] = '0;
    end else if (m_act) begin
      ev = 1;
      eo = sample(m_n);
      m_n++;
      if (m_n == m_len) begin
        m_act = 0;
        m_ptr = (m_ptr + 1) % 32;
      end
    end else if (m_inst[m_ptr][21:6] != 16'd0
                 && m_inst[m_ptr][49:22] == 28'(g)) begin
      m_act = 1;
      m_n   = 0;
      m_en  = m_inst[m_ptr][5:0];
      m_len = int'(m_inst[m_ptr][21:6]);
    end
    if (inst_list_wr_en) m_inst[inst_list_wr_addr] = inst_list_wr_data;
    if (sin_lut_wr_en)   m_lut[sin_lut_wr_addr] = sin_lut_wr_data;
    if (nco_ftw_wr_en && !rst && nco_ftw_wr_sel < 3'd6)
      m_ftw[nco_ftw_wr_sel] = nco_ftw_in;
    #1;
    if (valid_sin_wave_out === 1'b1) burst_cnt++;
    chk("valid", longint'(valid_sin_wave_out), longint'(ev));
    chk("sample", longint'(sin_wave_out), longint'(eo));
    inst_list_wr_en = 1'b0;
    sin_lut_wr_en   = 1'b0;
    nco_ftw_wr_en   = 1'b0;
  endtask

  task automatic wr_inst(input int a, input logic [49:0] d, input int g);
    inst_list_wr_en   = 1'b1;
    inst_list_wr_addr = 5'(a);
    inst_list_wr_data = d;
    step(g);
  endtask

  task automatic wr_lut(input int a, input int d, input int g);
    sin_lut_wr_en   = 1'b1;
    sin_lut_wr_addr = 8'(a);
    sin_lut_wr_data = 16'(d);
    step(g);
  endtask

  task automatic wr_ftw(input int q, input logic [23:0] f, input int g);
    nco_ftw_wr_en  = 1'b1;
    nco_ftw_wr_sel = 3'(q);
    nco_ftw_in     = f;
    step(g);
  endtask

  task automatic plan_ftws(input int g);
    for (int q = 0; q < 6; q++)
      wr_ftw(q, {3'(q), 1'b1, 4'b0, 16'b0}, g);
  endtask

  task automatic sweep(input int a, input int b);
    for (int g = a; g <= b; g++) step(g);
  endtask

  initial begin
    for (int q = 0; q < 6; q++) m_ftw[q] = '0;
    for (int i = 0; i < 256; i++) m_lut[i] = '0;
    for (int i = 0; i < 32; i++) m_inst[i] = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_valid", longint'(valid_sin_wave_out), 0);
    chk("reset_out", longint'(sin_wave_out), 0);

    // program list and LUT while held in reset
    for (int i = 0; i < 32; i++) wr_inst(i, '0, 5000);
    for (int i = 0; i < 256; i++)
      wr_lut(i, $rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * i / 256.0)), 5000);
    wr_inst(0, mk(0, 128, 6'b010101), 5000);
    wr_inst(1, mk(288, 64, 6'b101010), 5000);
    rst = 1'b0;
    plan_ftws(5000);
    chk("ptr_start", longint'(dut.ptr_q), longint'(m_ptr));

    burst_cnt = 0;
    sweep(0, 255);
    chk("burst0_len", burst_cnt, 128);
    burst_cnt = 0;
    sweep(256, 511);
    chk("burst1_len", burst_cnt, 64);
    chk("ptr_after_1", longint'(dut.ptr_q), 2);
    burst_cnt = 0;
    sweep(512, 600);
    chk("end_of_list", burst_cnt, 0);
    chk("ptr_hold", longint'(dut.ptr_q), 2);

    // async reset in the middle of a burst
    rst = 1'b1;
    step(5000);
    rst = 1'b0;
    plan_ftws(5000);
    sweep(0, 40);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", longint'(valid_sin_wave_out), 0);
    chk("async_out", longint'(sin_wave_out), 0);
    step(5000);
    rst = 1'b0;
    chk("ptr_after_rst", longint'(dut.ptr_q), 0);
    plan_ftws(5000);
    burst_cnt = 0;
    sweep(0, 140);
    chk("restart_len", burst_cnt, 128);

    // silent burst, then full-scale six-channel burst
    wr_inst(1, mk(1000, 10, 0), 5000);
    wr_inst(2, mk(1020, 20, 6'h3F), 5000);
    wr_inst(3, mk(1100, $urandom_range(40, 1), $urandom_range(63, 0)), 5000);
    wr_inst(4, '0, 5000);
    burst_cnt = 0;
    sweep(990, 1016);
    chk("silent_len", burst_cnt, 10);
    for (int i = 0; i < 256; i++) wr_lut(i, 32'h7FFF, 1016);
    sweep(1017, 1025);
    chk("full_scale", longint'(sin_wave_out), 196602);
    sweep(1026, 1050);

    // randomized LUT, FTWs and burst
    for (int i = 0; i < 256; i++) wr_lut(i, $urandom_range(65535, 0), 1051);
    for (int q = 0; q < 6; q++) wr_ftw(q, 24'($urandom), 1051);
    sweep(1052, 1160);
    chk("ptr_final", longint'(dut.ptr_q), longint'(m_ptr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
